// File: rtl/bytecode_fetch_ctrl_if.sv
// Memory request bus and decoded-byte stream of the bytecode fetch unit.
// master = fetch controller side, slave = memory/decoder side.
interface bytecode_fetch_ctrl_if #(
  parameter int unsigned ADDRESS_WIDTH = 8
);
  logic [ADDRESS_WIDTH-1:0] mem_address;
  logic                     mem_start;
  logic                     mem_rwn;
  logic [7:0]               mem_data;
  logic                     mem_ready;
  logic                     out_valid;
  logic [7:0]               out_byte;
  logic [ADDRESS_WIDTH-1:0] out_pc;
  logic                     out_ready;

  modport master (
    output mem_address,
    output mem_start,
    output mem_rwn,
    input  mem_data,
    input  mem_ready,
    output out_valid,
    output out_byte,
    output out_pc,
    input  out_ready
  );

  modport slave (
    input  mem_address,
    input  mem_start,
    input  mem_rwn,
    output mem_data,
    output mem_ready,
    input  out_valid,
    input  out_byte,
    input  out_pc,
    output out_ready
  );
endinterface

// File: rtl/bytecode_fetch_ctrl.sv
// Bytecode fetch sequencer: owns the PC, reads jvm_memory one byte at a
// time and buffers PC-tagged bytes for the decoder; redirects flush.
module bytecode_fetch_ctrl #(
  parameter int unsigned              ADDRESS_WIDTH = 8,
  parameter int unsigned              FIFO_DEPTH    = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     busy,
  bytecode_fetch_ctrl_if.master    bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = ADDRESS_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   pc;
  logic [AW-1:0]   pc_nxt;
  logic [AW-1:0]   req_pc;
  logic [AW-1:0]   req_pc_nxt;
  logic            push;
  logic            pop;
  logic            flush;

  logic [7:0]      byte_q [FIFO_DEPTH];
  logic [AW-1:0]   pc_q   [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_after_pop;

  assign pop             = (count != '0) && bus.out_ready;
  assign count_after_pop = count - CW'(pop);

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    req_pc_nxt = req_pc;
    push       = 1'b0;
    flush      = 1'b0;
    if (redirect_valid) begin
      pc_nxt = redirect_pc;
      flush  = 1'b1;
    end
    unique case (state)
      IDLE: begin
        // Credit check: only issue when the byte is sure to find a slot.
        if (!redirect_valid && run &&
            (count_after_pop < CW'(FIFO_DEPTH))) begin
          req_pc_nxt = pc;
          pc_nxt     = pc + AW'(1);
          state_nxt  = REQ;
        end
      end
      REQ: begin
        if (bus.mem_ready) begin
          push      = !redirect_valid;
          state_nxt = IDLE;
        end else if (redirect_valid) begin
          state_nxt = DISCARD;
        end
      end
      DISCARD: begin
        if (bus.mem_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      req_pc <= req_pc_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      byte_q[wr_ptr] <= bus.mem_data;
      pc_q[wr_ptr]   <= req_pc;
    end
  end

  assign busy            = (state != IDLE);
  assign bus.mem_start   = (state != IDLE);
  assign bus.mem_address = bus.mem_start ? req_pc : '0;
  assign bus.mem_rwn     = 1'b1;
  assign bus.out_valid   = (count != '0);
  assign bus.out_byte    = bus.out_valid ? byte_q[rd_ptr] : '0;
  assign bus.out_pc      = bus.out_valid ? pc_q[rd_ptr] : '0;
endmodule
